counter_pulse: RTL and testbench
================================

// Module: counter_pulse
// PURPOSE
//   Enable-gated modulo counter that emits a one-cycle terminal-count pulse.
//   Counts clock edges on which en is high, wrapping from MAX to 0.
//   Asserts out_p for exactly one clock on each wrap.
//   Used as a divided-rate tick or strobe generator for downstream logic.
// PARAMETERS
//   WIDTH  8  counter register width in bits
//   MAX    3  terminal count; the count runs 0..MAX, so the period is MAX+1 enabled cycles
// PORTS
//   clk    in   1  single clock; all state updates on its rising edge
//   rst    in   1  reset; synchronous, active-low (rst==0 at posedge clk resets)
//   en     in   1  count enable, sampled at posedge clk
//   out_p  out  1  registered terminal-count pulse, one clock wide
// BEHAVIOUR
//   - Internal state: cnt[WIDTH-1:0] and the out_p register. No other state.
//   - Reset (rst==0 at posedge):
//       cnt <= 0, out_p <= 0.
//       Reset takes priority over en.
//       Reset mid-count discards progress and suppresses any pending pulse.
//   - rst==1, en==1, cnt!=MAX: cnt <= cnt+1, out_p <= 0.
//   - rst==1, en==1, cnt==MAX: cnt <= 0, out_p <= 1 (wrap).
//   - rst==1, en==0: cnt holds, out_p <= 0.
//   - Pulse timing: out_p is high during the cycle after the (MAX+1)th enabled edge since
//     reset or the last wrap. Latency from that edge to the pulse is 0 extra cycles, since
//     out_p is the register output.
//   - With en held high, out_p is periodic: period MAX+1 clocks, duty 1 clock.
//   - Deasserting en pauses counting without loss. A later re-enable resumes from the held cnt.
//   - If en drops on the edge after a wrap, out_p still falls; the pulse is never stretched.
//   - MAX==0: every enabled edge wraps, so out_p equals en delayed one clock.
//   - Arithmetic is unsigned. The increment is never allowed to overflow WIDTH.
//   - Elaboration constraint: 0 <= MAX <= 2**WIDTH-1. Violation is a fatal elaboration error.
//   - en/rst are synchronous inputs from the clk domain; no internal synchronizers.
//   - Until the first reset, cnt and out_p are undefined. The bench must reset first.
// TESTING
//   1. rst=0 for 2 clks with en=1 -> cnt=0 and out_p=0 after each edge.
//   2. Release rst=1, en=1 for 5 clks (MAX=3) -> cnt 1,2,3,0,1. out_p=1 only after edge 4.
//   3. en=1 for 12 clks -> out_p high after edges 4, 8 and 12. It is low on all other cycles.
//   4. en pattern 1,1,0,0,0,1,1 -> cnt 1,2,2,2,2,3,0. out_p=1 only after the last edge.
//   5. At cnt==3 with en=1, drive rst=0 for 1 clk -> cnt=0, out_p=0, no pulse.
//      Resume en=1 -> first pulse after 4 more enabled edges.
//   6. MAX=0, WIDTH=1, en toggling 1,0,1,1,0 -> out_p 1,0,1,1,0, delayed one clk from en.

Source files
------------

// File: rtl/counter_pulse.sv
// Enable-gated modulo counter (0..MAX) that emits a registered one-clock pulse
// on every wrap from MAX back to 0.
module counter_pulse #(
  parameter int WIDTH = 8,
  parameter int MAX   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic out_p
);

  if (WIDTH < 1 || MAX < 0 || (WIDTH < 31 && MAX > (1 << WIDTH) - 1)) begin : g_bad_max
    $fatal(1, "counter_pulse: MAX=%0d does not fit in WIDTH=%0d", MAX, WIDTH);
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == MAX_C);

  // Wrap is decided by compare before incrementing, so cnt+1 never exceeds MAX.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      out_p <= 1'b0;
    end else if (en) begin
      if (at_max) begin
        cnt   <= '0;
        out_p <= 1'b1;
      end else begin
        cnt   <= cnt + WIDTH'(1);
        out_p <= 1'b0;
      end
    end else begin
      out_p <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_pulse.sv
// Scoreboard bench for counter_pulse: the driver queues expected post-edge values,
// a negedge monitor pops and compares them against the DUT.
module tb_counter_pulse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b0, en_a = 1'b0, p_a;
  logic rst_b = 1'b0, en_b = 1'b0, p_b;

  counter_pulse #(.WIDTH(8), .MAX(3)) dut (
    .clk(clk), .rst(rst_a), .en(en_a), .out_p(p_a)
  );

  counter_pulse #(.WIDTH(1), .MAX(0)) dut0 (
    .clk(clk), .rst(rst_b), .en(en_b), .out_p(p_b)
  );

  typedef struct {
    int         id;
    logic [7:0] cnt;
    logic       p;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   fails  = 0;
  int   step_id = 0;

  // Monitor: outputs are stable around the falling edge.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      exp_t e;
      e = q_a.pop_front();
      checks++;
      if (dut.cnt !== e.cnt) begin
        fails++;
        $display("FAIL cnt step %0d: got %0d, expected %0d", e.id, dut.cnt, e.cnt);
      end
      checks++;
      if (p_a !== e.p) begin
        fails++;
        $display("FAIL out_p step %0d: got %b, expected %b", e.id, p_a, e.p);
      end
    end
    if (q_b.size() > 0) begin
      exp_t e;
      e = q_b.pop_front();
      checks++;
      if (p_b !== e.p) begin
        fails++;
        $display("FAIL out_p(MAX=0) step %0d: got %b, expected %b", e.id, p_b, e.p);
      end
    end
  end

  task automatic step_a(input logic r, input logic e, input logic [7:0] c, input logic p);
    exp_t x;
    @(negedge clk);
    rst_a = r;
    en_a  = e;
    @(posedge clk);
    #1;
    step_id++;
    x.id = step_id; x.cnt = c; x.p = p;
    q_a.push_back(x);
  endtask

  task automatic step_b(input logic r, input logic e, input logic p);
    exp_t x;
    @(negedge clk);
    rst_b = r;
    en_b  = e;
    @(posedge clk);
    #1;
    step_id++;
    x.id = step_id; x.cnt = '0; x.p = p;
    q_b.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset dominates en
    step_a(0, 1, 0, 0);
    step_a(0, 1, 0, 0);
    // 2: count 1,2,3,0,1 with pulse after the 4th edge
    step_a(1, 1, 1, 0);
    step_a(1, 1, 2, 0);
    step_a(1, 1, 3, 0);
    step_a(1, 1, 0, 1);
    step_a(1, 1, 1, 0);
    // 3: 12 enabled edges from reset, pulses after 4, 8, 12
    step_a(0, 1, 0, 0);
    step_a(1, 1, 1, 0); step_a(1, 1, 2, 0); step_a(1, 1, 3, 0); step_a(1, 1, 0, 1);
    step_a(1, 1, 1, 0); step_a(1, 1, 2, 0); step_a(1, 1, 3, 0); step_a(1, 1, 0, 1);
    step_a(1, 1, 1, 0); step_a(1, 1, 2, 0); step_a(1, 1, 3, 0); step_a(1, 1, 0, 1);
    // 4: pause/resume, then en drops right after the wrap
    step_a(0, 0, 0, 0);
    step_a(1, 1, 1, 0); step_a(1, 1, 2, 0);
    step_a(1, 0, 2, 0); step_a(1, 0, 2, 0); step_a(1, 0, 2, 0);
    step_a(1, 1, 3, 0); step_a(1, 1, 0, 1);
    step_a(1, 0, 0, 0);
    // 5: reset at cnt==3 suppresses the pending pulse
    step_a(0, 0, 0, 0);
    step_a(1, 1, 1, 0); step_a(1, 1, 2, 0); step_a(1, 1, 3, 0);
    step_a(0, 1, 0, 0);
    step_a(1, 1, 1, 0); step_a(1, 1, 2, 0); step_a(1, 1, 3, 0); step_a(1, 1, 0, 1);
    step_a(1, 0, 0, 0);
    // 6: MAX=0, out_p is en delayed one clock
    step_b(0, 0, 0);
    step_b(1, 1, 1);
    step_b(1, 0, 0);
    step_b(1, 1, 1);
    step_b(1, 1, 1);
    step_b(1, 0, 0);

    for (int i = 0; i < 20 && (q_a.size() > 0 || q_b.size() > 0); i++) @(negedge clk);
    @(posedge clk);
    checks++;
    if (q_a.size() + q_b.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q_a.size() + q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
